// File: rtl/pe_feeder_if.sv
// Operand-stream bundle for pe_feeder: command, SRAM read port and PE beat outputs.
// The feeder takes the master view; the command source, SRAM and PE side take the slave view.
interface pe_feeder_if #(
    parameter int CNT_WIDTH  = 8,
    parameter int PREC_WIDTH = 2,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 10
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_base_addr;
    logic [CNT_WIDTH-1:0]  cmd_len;
    logic                  cmd_type;
    logic [PREC_WIDTH-1:0] cmd_precision;
    logic                  abort;
    logic                  rd_avail;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  data_valid;
    logic [CNT_WIDTH-1:0]  data_cnt;
    logic                  data_type;
    logic [PREC_WIDTH-1:0] precision;
    logic [DATA_WIDTH-1:0] data;
    logic                  done;

    modport master (
        input  cmd_valid, cmd_base_addr, cmd_len, cmd_type, cmd_precision,
        input  abort, rd_avail, rd_data,
        output cmd_ready, rd_en, rd_addr,
        output data_valid, data_cnt, data_type, precision, data, done
    );

    modport slave (
        output cmd_valid, cmd_base_addr, cmd_len, cmd_type, cmd_precision,
        output abort, rd_avail, rd_data,
        input  cmd_ready, rd_en, rd_addr,
        input  data_valid, data_cnt, data_type, precision, data, done
    );
endinterface

// File: rtl/pe_feeder.sv
// Issue side of the PE operand stream: reads len words from the operand SRAM and
// presents them as single-cycle tagged beats, two cycles after each read strobe.
module pe_feeder #(
    parameter int CNT_WIDTH  = 8,
    parameter int PREC_WIDTH = 2,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    pe_feeder_if.master   bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [CNT_WIDTH-1:0]  len_q;
    logic [CNT_WIDTH-1:0]  idx;
    logic                  type_q;
    logic [PREC_WIDTH-1:0] prec_q;
    logic                  s1_valid;
    logic [CNT_WIDTH-1:0]  s1_cnt;
    logic                  rd_fire;
    logic                  abort_hit;
    logic                  last_read;

    // Abort only has meaning while a command is in flight.
    assign abort_hit = bus.abort && (state != IDLE);
    assign rd_fire   = (state == RUN) && bus.rd_avail && !bus.abort;
    assign last_read = (idx == len_q - CNT_WIDTH'(1));

    assign bus.rd_en   = rd_fire;
    assign bus.rd_addr = base_q + ADDR_WIDTH'(idx);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order; blocking here creates races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            bus.cmd_ready <= 1'b1;
            bus.done      <= 1'b0;
            base_q        <= '0;
            len_q         <= '0;
            idx           <= '0;
            type_q        <= 1'b0;
            prec_q        <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        base_q        <= bus.cmd_base_addr;
                        len_q         <= bus.cmd_len;
                        type_q        <= bus.cmd_type;
                        prec_q        <= bus.cmd_precision;
                        idx           <= '0;
                        bus.cmd_ready <= 1'b0;
                        if (bus.cmd_len == '0) begin
                            state    <= DONE;
                            bus.done <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (abort_hit) begin
                        state         <= IDLE;
                        bus.cmd_ready <= 1'b1;
                    end else if (rd_fire) begin
                        idx <= idx + CNT_WIDTH'(1);
                        if (last_read) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (abort_hit) begin
                        state         <= IDLE;
                        bus.cmd_ready <= 1'b1;
                    end else if (!s1_valid && bus.data_valid) begin
                        // The final beat is on the outputs this cycle; done follows it.
                        state    <= DONE;
                        bus.done <= 1'b1;
                    end
                end
                DONE: begin
                    state         <= IDLE;
                    bus.cmd_ready <= 1'b1;
                end
                default: begin
                    state         <= IDLE;
                    bus.cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    // Read-data pipeline: s1 tracks the outstanding SRAM read, the output stage
    // captures rd_data the cycle it returns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid       <= 1'b0;
            s1_cnt         <= '0;
            bus.data_valid <= 1'b0;
            bus.data_cnt   <= '0;
            bus.data_type  <= 1'b0;
            bus.precision  <= '0;
            bus.data       <= '0;
        end else begin
            s1_valid <= rd_fire;
            if (rd_fire) s1_cnt <= idx;

            if (abort_hit) begin
                bus.data_valid <= 1'b0;
            end else if (s1_valid) begin
                bus.data_valid <= 1'b1;
                bus.data_cnt   <= s1_cnt;
                bus.data       <= bus.rd_data;
                bus.data_type  <= type_q;
                bus.precision  <= prec_q;
            end else begin
                bus.data_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pe_feeder.sv
// Self-checking bench for pe_feeder: directed scenarios plus randomized commands,
// each checked against an SRAM image and a read/beat/done timing model.
module tb_pe_feeder;
    localparam int CW = 8;
    localparam int PW = 2;
    localparam int DW = 64;
    localparam int AW = 10;
    localparam int DEPTH = 1 << AW;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
    } rd_t;

    typedef struct {
        int            cyc;
        logic [CW-1:0] cnt;
        logic          typ;
        logic [PW-1:0] prec;
        logic [DW-1:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pe_feeder_if #(.CNT_WIDTH(CW), .PREC_WIDTH(PW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    pe_feeder #(.CNT_WIDTH(CW), .PREC_WIDTH(PW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [DW-1:0] mem [DEPTH];
    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    bit    avail_hist [int];
    bit    ready_hist [int];
    int    acc_q [$];
    rd_t   rd_q [$];
    beat_t beat_q [$];
    int    done_q [$];

    // SRAM with one-cycle read latency.
    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
    end

    // Monitor: sample everything mid-cycle and log events with their cycle number.
    always @(negedge clk) begin
        if (rst_n) begin
            rd_t   r;
            beat_t b;
            avail_hist[cyc] = bus.rd_avail;
            ready_hist[cyc] = bus.cmd_ready;
            if (bus.cmd_valid && bus.cmd_ready) acc_q.push_back(cyc);
            if (bus.rd_en) begin
                r.cyc = cyc; r.addr = bus.rd_addr;
                rd_q.push_back(r);
            end
            if (bus.data_valid) begin
                b.cyc = cyc; b.cnt = bus.data_cnt; b.typ = bus.data_type;
                b.prec = bus.precision; b.data = bus.data;
                beat_q.push_back(b);
            end
            if (bus.done) done_q.push_back(cyc);
        end
        cyc++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        acc_q.delete(); rd_q.delete(); beat_q.delete(); done_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, bus.cmd_ready, 1);
        check({tag, "_rd_en"}, bus.rd_en, 0);
        check({tag, "_data_valid"}, bus.data_valid, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_payload"}, {bus.data_cnt, bus.data_type, bus.precision}, 0);
        check({tag, "_data"}, bus.data, 0);
    endtask

    // Model: reads happen on the first len read-permitted cycles after acceptance
    // (none from the abort cycle on); beat i carries mem[base+i] two cycles after
    // its read; done follows the last beat by one cycle (acceptance+1 for len 0).
    task automatic verify(input int a, input int len, input int base, input int typ,
                          input int prec, input int abort_at);
        int exp_rd [$];
        int x;
        int c;
        int n;
        int n_beats;
        int addr;
        x = (abort_at != 0) ? a + abort_at : 32'h3fff_ffff;
        c = a + 1;
        while (exp_rd.size() < len && c < x && avail_hist.exists(c)) begin
            if (avail_hist[c]) exp_rd.push_back(c);
            c++;
        end
        check("busy_after_accept", ready_hist[a + 1], 0);
        check("rd_count", rd_q.size(), exp_rd.size());
        n = (rd_q.size() < exp_rd.size()) ? rd_q.size() : exp_rd.size();
        for (int i = 0; i < n; i++) begin
            check("rd_cycle", rd_q[i].cyc, exp_rd[i]);
            check("rd_addr", rd_q[i].addr, (base + i) % DEPTH);
        end
        n_beats = 0;
        foreach (exp_rd[i]) if (exp_rd[i] + 2 <= x) n_beats++;
        check("beat_count", beat_q.size(), n_beats);
        n = (beat_q.size() < n_beats) ? beat_q.size() : n_beats;
        for (int i = 0; i < n; i++) begin
            addr = (base + i) % DEPTH;
            check("beat_cycle", beat_q[i].cyc, exp_rd[i] + 2);
            check("beat_cnt", beat_q[i].cnt, i);
            check("beat_data", beat_q[i].data, mem[addr]);
            check("beat_tag", {beat_q[i].typ, beat_q[i].prec}, {typ[0], prec[PW-1:0]});
        end
        if (abort_at != 0) begin
            check("no_done_after_abort", done_q.size(), 0);
            check("ready_after_abort", ready_hist[x + 1], 1);
        end else begin
            check("done_count", done_q.size(), 1);
            if (done_q.size() > 0 && exp_rd.size() == len)
                check("done_cycle", done_q[0], (len == 0) ? a + 1 : exp_rd[len - 1] + 3);
        end
    endtask

    // Offer a command, run it with the chosen read-permit pattern, then check it.
    task automatic run_cmd(input int base, input int len, input int typ, input int prec,
                           input int hold, input bit rnd, input int abort_at);
        int a;
        clear_logs();
        bus.cmd_base_addr = base[AW-1:0];
        bus.cmd_len       = len[CW-1:0];
        bus.cmd_type      = typ[0];
        bus.cmd_precision = prec[PW-1:0];
        bus.cmd_valid     = 1'b1;
        bus.rd_avail      = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid     = 1'b0;
        // Scramble the command bus so only latched values can reach the beats.
        bus.cmd_type      = ~bus.cmd_type;
        bus.cmd_precision = ~bus.cmd_precision;
        bus.cmd_base_addr = ~bus.cmd_base_addr;
        bus.cmd_len       = ~bus.cmd_len;
        check("accepted", acc_q.size(), 1);
        if (acc_q.size() != 1) return;
        a = acc_q[0];
        for (int k = 1; k <= 400; k++) begin
            bus.rd_avail = rnd ? 1'($urandom_range(0, 1)) : (k != hold);
            bus.abort    = (k == abort_at);
            @(posedge clk); #1;
            if (abort_at == 0 && done_q.size() > 0) break;
            if (abort_at != 0 && k >= abort_at + 2) break;
        end
        bus.abort    = 1'b0;
        bus.rd_avail = 1'b0;
        @(posedge clk); #1;
        verify(a, len, base, typ, prec, abort_at);
        @(negedge clk);
        check("ready_when_idle", bus.cmd_ready, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        int len;
        bus.cmd_valid = 1'b0; bus.cmd_base_addr = '0; bus.cmd_len = '0;
        bus.cmd_type = 1'b0; bus.cmd_precision = '0; bus.abort = 1'b0;
        bus.rd_avail = 1'b0; bus.rd_data = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom};
        for (int i = 0; i < 4; i++) mem[16 + i] = 64'(160 + i);

        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Basic streaming command.
        run_cmd('h010, 4, 1, 2, 0, 1'b0, 0);
        if (beat_q.size() == 4) begin
            check("dir_first_data", beat_q[0].data, 64'hA0);
            check("dir_last_data", beat_q[3].data, 64'hA3);
        end
        if (rd_q.size() > 0 && done_q.size() > 0)
            check("dir_done_T+6", done_q[0], rd_q[0].cyc + 6);

        // One-cycle read bubble on the second RUN cycle.
        run_cmd('h010, 4, 0, 1, 2, 1'b0, 0);

        // Zero-length command.
        run_cmd('h123, 0, 1, 3, 0, 1'b0, 0);

        // Address wrap at the top of the SRAM.
        run_cmd('h3FE, 4, 1, 1, 0, 1'b0, 0);
        if (rd_q.size() == 4) check("wrap_addr2", rd_q[2].addr, 0);

        // Abort after three reads, then a normal command.
        run_cmd('h040, 8, 0, 2, 0, 1'b0, 4);
        run_cmd('h080, 3, 1, 0, 0, 1'b0, 0);

        // Reset in the middle of RUN.
        clear_logs();
        bus.cmd_base_addr = 10'h200; bus.cmd_len = 8'd8; bus.cmd_type = 1'b1;
        bus.cmd_precision = 2'd3; bus.cmd_valid = 1'b1; bus.rd_avail = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrun_reset");
        @(negedge clk);
        check("midrun_reset_valid2", bus.data_valid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_logs();
        repeat (6) @(posedge clk);
        #1;
        check("post_reset_no_reads", rd_q.size(), 0);
        check("post_reset_no_beats", beat_q.size() + done_q.size(), 0);
        bus.rd_avail = 1'b0;
        run_cmd('h300, 5, 0, 3, 0, 1'b0, 0);

        // Randomized commands with random read permits.
        for (int t = 0; t < 8; t++) begin
            len = (t == 0) ? 0 : int'($urandom_range(1, 30));
            run_cmd(int'($urandom_range(0, DEPTH - 1)), len, int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)), 0, 1'b1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
